// File: rtl/branch_predictor_if.sv
// Fetch/execute signal bundle between the pipeline and the branch predictor.
// BP_PERF_EN adds the performance-counter outputs and the br_predictE input.
interface branch_predictor_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] PCF;
   logic            br_predictF;
   logic [XLEN-1:0] PCPredF;
   logic [XLEN-1:0] PCE;
   logic [XLEN-1:0] PCTargetE;
   logic            JumpE;
   logic            JumprE;
   logic            BranchE;
   logic            br_takenE;
`ifdef BP_PERF_EN
   logic            br_predictE;
   logic [31:0]     bp_branches;
   logic [31:0]     bp_mispredicts;

   modport master (
      output PCF, PCE, PCTargetE, JumpE, JumprE, BranchE, br_takenE, br_predictE,
      input  br_predictF, PCPredF, bp_branches, bp_mispredicts
   );
   modport slave (
      input  PCF, PCE, PCTargetE, JumpE, JumprE, BranchE, br_takenE, br_predictE,
      output br_predictF, PCPredF, bp_branches, bp_mispredicts
   );
`else
   modport master (
      output PCF, PCE, PCTargetE, JumpE, JumprE, BranchE, br_takenE,
      input  br_predictF, PCPredF
   );
   modport slave (
      input  PCF, PCE, PCTargetE, JumpE, JumprE, BranchE, br_takenE,
      output br_predictF, PCPredF
   );
`endif
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, looked up at Fetch, trained from Execute.
// Optional BP_PERF_EN adds branch and mispredict counters.
module branch_predictor #(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 64
) (
   input logic              clk,
   input logic              rst,
   branch_predictor_if.slave bus
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;

   logic             valid   [ENTRIES];
   logic [TAG_W-1:0] tags    [ENTRIES];
   logic [XLEN-1:0]  targets [ENTRIES];
   logic             is_jump [ENTRIES];
   logic [1:0]       ctr     [ENTRIES];

   logic [IDX_W-1:0] idx_f;
   logic [IDX_W-1:0] idx_e;
   logic [TAG_W-1:0] tag_f;
   logic [TAG_W-1:0] tag_e;
   logic             hit_f;
   logic             hit_e;
   logic             predict;
   logic             unused_low;

   assign idx_f = bus.PCF[IDX_W+1:2];
   assign tag_f = bus.PCF[XLEN-1:IDX_W+2];
   assign idx_e = bus.PCE[IDX_W+1:2];
   assign tag_e = bus.PCE[XLEN-1:IDX_W+2];
   assign unused_low = ^{bus.PCF[1:0], bus.PCE[1:0]};

   assign hit_f   = valid[idx_f] && (tags[idx_f] == tag_f);
   assign hit_e   = valid[idx_e] && (tags[idx_e] == tag_e);
   assign predict = hit_f && (is_jump[idx_f] || ctr[idx_f][1]);

   assign bus.br_predictF = predict;
   assign bus.PCPredF     = predict ? targets[idx_f] : bus.PCF + XLEN'(4);

   // JALR is deliberately absent here: it is never trained and so never predicted.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid[i] <= 1'b0;
            ctr[i]   <= 2'b01;
         end
      end else if (bus.JumpE) begin
         valid[idx_e]   <= 1'b1;
         tags[idx_e]    <= tag_e;
         targets[idx_e] <= bus.PCTargetE;
         is_jump[idx_e] <= 1'b1;
         ctr[idx_e]     <= 2'b11;
      end else if (bus.BranchE) begin
         if (hit_e) begin
            is_jump[idx_e] <= 1'b0;
            if (bus.br_takenE) begin
               ctr[idx_e]     <= (ctr[idx_e] == 2'b11) ? 2'b11 : ctr[idx_e] + 2'd1;
               targets[idx_e] <= bus.PCTargetE;
            end else begin
               ctr[idx_e]     <= (ctr[idx_e] == 2'b00) ? 2'b00 : ctr[idx_e] - 2'd1;
            end
         end else if (bus.br_takenE) begin
            valid[idx_e]   <= 1'b1;
            tags[idx_e]    <= tag_e;
            targets[idx_e] <= bus.PCTargetE;
            is_jump[idx_e] <= 1'b0;
            ctr[idx_e]     <= 2'b10;
         end
      end
   end

`ifdef BP_PERF_EN
   logic [31:0] branches_q;
   logic [31:0] mispredicts_q;
   logic        is_ctrl;
   logic        redirect;
   logic        mispredict;

   assign is_ctrl    = bus.JumpE || bus.JumprE || bus.BranchE;
   assign redirect   = bus.JumpE || bus.JumprE || (bus.BranchE && bus.br_takenE);
   assign mispredict = is_ctrl && (redirect != bus.br_predictE);

   always_ff @(posedge clk) begin
      if (rst) begin
         branches_q    <= '0;
         mispredicts_q <= '0;
      end else begin
         if (is_ctrl)    branches_q    <= branches_q + 32'd1;
         if (mispredict) mispredicts_q <= mispredicts_q + 32'd1;
      end
   end

   assign bus.bp_branches    = branches_q;
   assign bus.bp_mispredicts = mispredicts_q;
`endif
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage dynamic branch predictor: direct-mapped BTB plus 2-bit saturating direction counters.
- Looks up PCF combinationally and produces the predicted next fetch PC and br_predictF.
- br_predictF rides the pipeline registers to Execute, where pc_src compares it against the resolved outcome.
- Trained from Execute-stage resolution signals, written at the clock edge.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 64, number of BTB entries; power of two, minimum 4.
- IDX_W, $clog2(ENTRIES), index width. Index = PC[IDX_W+1:2].
- TAG_W, XLEN-IDX_W-2, tag width. Tag = PC[XLEN-1:IDX_W+2].

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- PCF  in  XLEN  fetch PC being looked up.
- br_predictF  out  1  predicted redirect for the instruction at PCF.
- PCPredF  out  XLEN  predicted next PC: stored target if br_predictF, else PCF+4.
- PCE  in  XLEN  PC of the instruction in Execute.
- PCTargetE  in  XLEN  resolved PCE+ImmExtE target.
- JumpE  in  1  JAL in Execute.
- JumprE  in  1  JALR in Execute.
- BranchE  in  1  conditional branch in Execute.
- br_takenE  in  1  resolved branch condition.

Behaviour:
- Per-entry state: valid, tag[TAG_W], target[XLEN], is_jump, ctr[1:0].
- Reset: all valid=0 and ctr=2'b01 on the first rising edge with rst=1. Other fields are don't-care. rst has priority over any update in the same cycle.
- Reset effect on outputs: table read is combinational, so from the edge after reset: br_predictF=0 and PCPredF=PCF+4 for every PCF.
- Lookup (0-cycle, combinational):
  - hit = valid[idx] & (tag[idx]==tagF).
  - br_predictF = hit & (is_jump[idx] | ctr[idx][1]).
  - PCPredF = br_predictF ? target[idx] : PCF+4. Addition is modulo 2^XLEN, so 0xFFFFFFFC+4 wraps to 0.
- Update at the rising edge, at most one per cycle. Bubbles and flushed slots carry JumpE=BranchE=JumprE=0, so each instruction trains exactly once.
  - JumpE=1: write entry idx(PCE) with valid=1, tag, target=PCTargetE, is_jump=1, ctr=2'b11. Overwrites any aliasing entry.
  - BranchE=1 and hit on PCE:
    - taken: ctr saturating +1 (max 2'b11), target=PCTargetE.
    - not taken: ctr saturating -1 (min 2'b00), target unchanged.
    - is_jump cleared.
  - BranchE=1, miss, taken: allocate with valid=1, tag, target=PCTargetE, is_jump=0, ctr=2'b10.
  - BranchE=1, miss, not taken: no change.
  - JumprE=1: no change. JALR is never predicted, so br_predictF=0 and pc_src always flags it as mispredict.
  - Multiple of JumpE/BranchE/JumprE set: illegal. Priority JumpE > BranchE.
- Same-cycle update and lookup to the same index: lookup returns the pre-update contents. The new contents are visible the following cycle. No bypass.
- No stall input. Lookup is pure combinational and the update is gated only by E-stage control.

Optional Feature:
- Macro: BP_PERF_EN.
- When defined, adds outputs bp_branches [31:0] and bp_mispredicts [31:0].
  - bp_branches increments on every cycle with JumpE|JumprE|BranchE.
  - bp_mispredicts increments when pc_src's mispredict condition holds. This requires an extra input br_predictE [1].
  - Both clear on rst and wrap modulo 2^32.
- When undefined, these ports and the input br_predictE do not exist, and no counter logic is generated.

Test Plan:
1. Reset, then PCF=0x100 -> br_predictF=0, PCPredF=0x104.
2. BranchE=1, br_takenE=1, PCE=0x100, PCTargetE=0x80 -> next cycle PCF=0x100 gives br_predictF=1, PCPredF=0x80 (ctr=10).
3. Two further updates at 0x100 with br_takenE=0:
   - after the first, ctr=01 and PCF=0x100 gives br_predictF=0, PCPredF=0x104;
   - after the second, ctr=00;
   - then three taken updates saturate ctr at 11.
4. JumpE at PCE=0x200, PCTargetE=0x400 -> PCF=0x200 predicts 1 / 0x400. JumprE at PCE=0x300 -> PCF=0x300 stays 0 / 0x304.
5. Aliasing (ENTRIES=64):
   - Train a taken branch at 0x100, then look up PCF=0x200 (same index 0, different tag) -> miss, 0 / 0x204.
   - Then JumpE at 0x200 -> 0x100 now misses.
6. Update at PCE=0x100 while PCF=0x100 in the same cycle -> old prediction that cycle, new one next. Assert rst mid-stream -> all lookups miss afterwards. Under BP_PERF_EN, both counters read 0 after reset.
